// File: rtl/ble_packet_sync.sv
// BLE access-address correlator and packet framer: finds the access address,
// dewhitens the header and payload, and delimits packets by their length field.
module ble_packet_sync #(
   parameter logic [31:0] AA      = 32'h8E89BED6,
   parameter int unsigned MAX_ERR = 0,
   parameter int unsigned MAX_LEN = 37
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       bit_valid,
   input  logic       bit_in,
   input  logic [5:0] channel,
   output logic       sync_found,
   output logic [7:0] byte_out,
   output logic       byte_valid,
   output logic       pkt_end,
   output logic       pkt_err,
   output logic       busy
);

   typedef enum logic [1:0] {SEARCH, HEADER, PAYLOAD} state_t;

   state_t      state, state_nx;
   logic [31:0] sr, sr_nx;
   logic [5:0]  sr_cnt, sr_cnt_nx;
   logic [6:0]  lfsr, lfsr_nx;
   logic [7:0]  acc, acc_nx;
   logic [2:0]  bit_idx, bit_idx_nx;
   logic        hdr_cnt, hdr_cnt_nx;
   logic [8:0]  remain, remain_nx;
   logic [7:0]  byte_out_nx;
   logic        sync_nx, bv_nx, end_nx, err_nx;

   logic        take;
   logic        data;
   logic [31:0] sr_shift;
   logic [5:0]  cnt_inc;
   logic [7:0]  acc_shift;
   logic [6:0]  lfsr_step;
   int unsigned mism;
   logic        match;

   // Datapath candidates for the current bit, selected by the FSM below.
   always_comb begin
      take      = enable & bit_valid;
      sr_shift  = {bit_in, sr[31:1]};
      mism      = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         mism += {31'd0, (sr_shift[i] ^ AA[i])};
      end
      cnt_inc   = (sr_cnt == 6'd32) ? sr_cnt : sr_cnt + 6'd1;
      match     = (cnt_inc == 6'd32) && (mism <= MAX_ERR);
      data      = bit_in ^ lfsr[6];
      acc_shift = {data, acc[7:1]};
      lfsr_step = {lfsr[5], lfsr[4], lfsr[3] ^ lfsr[6], lfsr[2],
                   lfsr[1], lfsr[0], lfsr[6]};
   end

   always_comb begin
      state_nx    = state;
      sr_nx       = sr;
      sr_cnt_nx   = sr_cnt;
      lfsr_nx     = lfsr;
      acc_nx      = acc;
      bit_idx_nx  = bit_idx;
      hdr_cnt_nx  = hdr_cnt;
      remain_nx   = remain;
      byte_out_nx = byte_out;
      sync_nx     = 1'b0;
      bv_nx       = 1'b0;
      end_nx      = 1'b0;
      err_nx      = 1'b0;

      if (!enable) begin
         // Any disable discards the partial byte and restarts correlation.
         state_nx   = SEARCH;
         sr_nx      = '0;
         sr_cnt_nx  = '0;
         acc_nx     = '0;
         bit_idx_nx = '0;
         hdr_cnt_nx = 1'b0;
         remain_nx  = '0;
      end else if (take) begin
         case (state)
            SEARCH: begin
               sr_nx     = sr_shift;
               sr_cnt_nx = cnt_inc;
               if (match) begin
                  state_nx   = HEADER;
                  sync_nx    = 1'b1;
                  lfsr_nx    = {channel[0], channel[1], channel[2], channel[3],
                                channel[4], channel[5], 1'b1};
                  sr_nx      = '0;
                  sr_cnt_nx  = '0;
                  acc_nx     = '0;
                  bit_idx_nx = '0;
                  hdr_cnt_nx = 1'b0;
               end
            end
            HEADER, PAYLOAD: begin
               lfsr_nx    = lfsr_step;
               acc_nx     = acc_shift;
               bit_idx_nx = bit_idx + 3'd1;
               if (bit_idx == 3'd7) begin
                  bv_nx       = 1'b1;
                  byte_out_nx = acc_shift;
                  if (state == HEADER) begin
                     if (!hdr_cnt) begin
                        hdr_cnt_nx = 1'b1;
                     end else if ({24'd0, acc_shift} > MAX_LEN) begin
                        end_nx   = 1'b1;
                        err_nx   = 1'b1;
                        state_nx = SEARCH;
                     end else begin
                        // PDU bytes plus three CRC bytes still to come.
                        remain_nx = {1'b0, acc_shift} + 9'd3;
                        state_nx  = PAYLOAD;
                     end
                  end else if (remain == 9'd1) begin
                     end_nx   = 1'b1;
                     state_nx = SEARCH;
                  end else begin
                     remain_nx = remain - 9'd1;
                  end
               end
            end
            default: state_nx = SEARCH;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= SEARCH;
         sr         <= '0;
         sr_cnt     <= '0;
         lfsr       <= '0;
         acc        <= '0;
         bit_idx    <= '0;
         hdr_cnt    <= 1'b0;
         remain     <= '0;
         byte_out   <= '0;
         sync_found <= 1'b0;
         byte_valid <= 1'b0;
         pkt_end    <= 1'b0;
         pkt_err    <= 1'b0;
      end else begin
         state      <= state_nx;
         sr         <= sr_nx;
         sr_cnt     <= sr_cnt_nx;
         lfsr       <= lfsr_nx;
         acc        <= acc_nx;
         bit_idx    <= bit_idx_nx;
         hdr_cnt    <= hdr_cnt_nx;
         remain     <= remain_nx;
         byte_out   <= byte_out_nx;
         sync_found <= sync_nx;
         byte_valid <= bv_nx;
         pkt_end    <= end_nx;
         pkt_err    <= err_nx;
      end
   end

   assign busy = (state != SEARCH);

endmodule

// File: tb/tb_ble_packet_sync.sv
// Bench for ble_packet_sync: packet table, corner sequences and random packets,
// each cycle compared against a bit-stream reference model.
module tb_ble_packet_sync;

   localparam logic [31:0] AA_V   = 32'h8E89BED6;
   localparam int          MAXLEN = 37;

   logic       clk       = 1'b0;
   logic       rst_n     = 1'b0;
   logic       enable    = 1'b0;
   logic       bit_valid = 1'b0;
   logic       bit_in    = 1'b0;
   logic [5:0] channel   = 6'd0;

   logic       sync_found, byte_valid, pkt_end, pkt_err, busy;
   logic [7:0] byte_out;
   logic       sync1, bv1, end1, err1, busy1;
   logic [7:0] byte1;

   always #5 clk = ~clk;

   ble_packet_sync #(.AA(AA_V), .MAX_ERR(0), .MAX_LEN(MAXLEN)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .bit_valid(bit_valid),
      .bit_in(bit_in), .channel(channel), .sync_found(sync_found),
      .byte_out(byte_out), .byte_valid(byte_valid), .pkt_end(pkt_end),
      .pkt_err(pkt_err), .busy(busy));

   ble_packet_sync #(.AA(AA_V), .MAX_ERR(1), .MAX_LEN(MAXLEN)) dut1 (
      .clk(clk), .rst_n(rst_n), .enable(enable), .bit_valid(bit_valid),
      .bit_in(bit_in), .channel(channel), .sync_found(sync1),
      .byte_out(byte1), .byte_valid(bv1), .pkt_end(end1),
      .pkt_err(err1), .busy(busy1));

   typedef struct packed {
      logic       sync;
      logic       bv;
      logic [7:0] bval;
      logic       pend;
      logic       perr;
      logic       busy;
   } exp_t;

   typedef struct {
      logic [5:0] ch;
      logic [7:0] h0;
      logic [7:0] len;
      int         flip;
      int         e_sync;
      int         e_bytes;
      int         e_end;
      int         e_err;
      int         e_sync1;
      int         e_bytes1;
   } vec_t;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   int c_sync, c_bv, c_end, c_err, c1_sync, c1_bv, c1_end, c1_err;
   logic [7:0] rx_q[$];
   logic [7:0] rx1_q[$];

   // Reference model state: the bit history since entering search, and
   // the received-bit position within the current packet.
   int         m_mode = 0;
   bit         m_hist[$];
   logic [5:0] m_ch;
   int         m_nbits, m_nbytes, m_total;
   logic [7:0] m_acc;

   function automatic logic wbit(input logic [5:0] ch, input int n);
      logic [6:0] w, nw;
      w[0] = 1'b1;
      for (int i = 1; i <= 6; i++) w[i] = ch[6 - i];
      for (int k = 0; k < n; k++) begin
         nw[0] = w[6];
         for (int i = 1; i <= 6; i++) nw[i] = w[i - 1];
         nw[4] = w[3] ^ w[6];
         w = nw;
      end
      return w[6];
   endfunction

   task automatic model_clear();
      m_mode = 0;
      m_hist.delete();
   endtask

   task automatic model_bit(input logic b, output exp_t e);
      int   errs;
      logic d;
      e = '0;
      if (m_mode == 0) begin
         m_hist.push_back(b);
         if (m_hist.size() > 32) void'(m_hist.pop_front());
         if (m_hist.size() == 32) begin
            errs = 0;
            for (int i = 0; i < 32; i++) if (m_hist[i] != AA_V[i]) errs++;
            if (errs == 0) begin
               e.sync   = 1'b1;
               m_mode   = 1;
               m_ch     = channel;
               m_nbits  = 0;
               m_nbytes = 0;
               m_total  = -1;
               m_acc    = '0;
               m_hist.delete();
            end
         end
      end else begin
         d = b ^ wbit(m_ch, m_nbits);
         m_acc[m_nbits % 8] = d;
         m_nbits++;
         if (m_nbits % 8 == 0) begin
            e.bv   = 1'b1;
            e.bval = m_acc;
            m_nbytes++;
            if (m_nbytes == 2) begin
               if (int'(m_acc) > MAXLEN) begin
                  e.pend = 1'b1;
                  e.perr = 1'b1;
                  model_clear();
               end else begin
                  m_total = int'(m_acc) + 5;
               end
            end else if (m_nbytes == m_total) begin
               e.pend = 1'b1;
               model_clear();
            end
         end
      end
      e.busy = (m_mode == 1);
   endtask

   task automatic check(input string nm, input int got, input int want);
      n_cmp++;
      if (got != want) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", nm, got, want);
      end
   endtask

   task automatic clear_tally();
      c_sync = 0; c_bv = 0; c_end = 0; c_err = 0;
      c1_sync = 0; c1_bv = 0; c1_end = 0; c1_err = 0;
      rx_q.delete();
      rx1_q.delete();
   endtask

   task automatic step(input logic rn, input logic en, input logic bv, input logic b);
      exp_t e;
      e = '0;
      rst_n = rn; enable = en; bit_valid = bv; bit_in = b;
      if (!rn || !en) model_clear();
      else if (bv) model_bit(b, e);
      else e.busy = (m_mode == 1);
      @(negedge clk);
      cyc++;
      n_cmp++;
      if (sync_found !== e.sync || byte_valid !== e.bv || pkt_end !== e.pend ||
          pkt_err !== e.perr || busy !== e.busy ||
          ((e.bv || !rn) && byte_out !== e.bval)) begin
         n_bad++;
         $display("FAIL cycle %0d: got sync=%b bv=%b byte=%h end=%b err=%b busy=%b, want sync=%b bv=%b byte=%h end=%b err=%b busy=%b",
                  cyc, sync_found, byte_valid, byte_out, pkt_end, pkt_err, busy,
                  e.sync, e.bv, e.bval, e.pend, e.perr, e.busy);
      end
      if (sync_found) c_sync++;
      if (byte_valid) begin c_bv++; rx_q.push_back(byte_out); end
      if (pkt_end) c_end++;
      if (pkt_err) c_err++;
      if (sync1) c1_sync++;
      if (bv1) begin c1_bv++; rx1_q.push_back(byte1); end
      if (end1) c1_end++;
      if (err1) c1_err++;
   endtask

   task automatic send_bit(input logic b);
      if ($urandom_range(0, 3) == 0)
         repeat ($urandom_range(1, 2)) step(1'b1, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
      step(1'b1, 1'b1, 1'b1, b);
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b1, 1'b1, 1'b0, 1'b0);
   endtask

   // nbody limits the whitened bits sent after the access address (-1 = whole packet).
   task automatic send_pkt(input logic [5:0] ch, input logic [7:0] h0, input logic [7:0] len,
                           input int flip, input int nbody);
      logic [7:0]  pre;
      logic [31:0] a;
      logic [7:0]  v;
      int          total;
      channel = ch;
      pre = 8'hAA;
      v   = '0;
      for (int i = 0; i < 8; i++) send_bit(pre[i]);
      a = AA_V;
      if (flip >= 0) a[flip] = ~a[flip];
      for (int i = 0; i < 32; i++) send_bit(a[i]);
      total = (int'(len) + 5) * 8;
      if (nbody >= 0) total = nbody;
      for (int k = 0; k < total; k++) begin
         if (k % 8 == 0) v = (k < 8) ? h0 : (k < 16) ? len : 8'($urandom);
         send_bit(v[k % 8] ^ wbit(ch, k));
      end
   endtask

   vec_t tbl[7];

   initial begin
      tbl[0] = '{6'd37, 8'h02, 8'd6,    -1, 1, 11, 1, 0, 1, 11};
      tbl[1] = '{6'd37, 8'h02, 8'h30,   -1, 1,  2, 1, 1, 1,  2};
      tbl[2] = '{6'd37, 8'h46, 8'd0,    -1, 1,  5, 1, 0, 1,  5};
      tbl[3] = '{6'd39, 8'h40, 8'd37,   -1, 1, 42, 1, 0, 1, 42};
      tbl[4] = '{6'd12, 8'h42, 8'd38,   -1, 1,  2, 1, 1, 1,  2};
      tbl[5] = '{6'd37, 8'h02, 8'd6,    13, 0,  0, 0, 0, 1, 11};
      tbl[6] = '{6'd0,  8'h00, 8'd1,    -1, 1,  6, 1, 0, 1,  6};

      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b1);
      check("reset_byte_out", int'(byte_out), 0);
      idle(2);

      for (int t = 0; t < 7; t++) begin
         clear_tally();
         send_pkt(tbl[t].ch, tbl[t].h0, tbl[t].len, tbl[t].flip, -1);
         idle(3);
         check($sformatf("t%0d_sync", t), c_sync, tbl[t].e_sync);
         check($sformatf("t%0d_bytes", t), c_bv, tbl[t].e_bytes);
         check($sformatf("t%0d_end", t), c_end, tbl[t].e_end);
         check($sformatf("t%0d_err", t), c_err, tbl[t].e_err);
         check($sformatf("t%0d_sync1", t), c1_sync, tbl[t].e_sync1);
         check($sformatf("t%0d_bytes1", t), c1_bv, tbl[t].e_bytes1);
         check($sformatf("t%0d_err1", t), c1_err, tbl[t].e_err);
         check($sformatf("t%0d_busy1", t), int'(busy1), 0);
         if (tbl[t].e_bytes >= 2 && rx_q.size() >= 2) begin
            check($sformatf("t%0d_hdr0", t), int'(rx_q[0]), int'(tbl[t].h0));
            check($sformatf("t%0d_len", t), int'(rx_q[1]), int'(tbl[t].len));
         end
         if (rx1_q.size() >= 2)
            check($sformatf("t%0d_len1", t), int'(rx1_q[1]), int'(tbl[t].len));
      end

      // Enable dropped 20 bits into the payload, with a bit on the falling edge.
      clear_tally();
      send_pkt(6'd37, 8'h02, 8'd10, -1, 36);
      step(1'b1, 1'b0, 1'b1, 1'b1);
      repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
      check("abort_no_end", c_end, 0);
      check("abort_bytes", c_bv, 4);
      check("abort_busy", int'(busy), 0);
      clear_tally();
      send_pkt(6'd37, 8'h02, 8'd6, -1, -1);
      idle(3);
      check("after_abort_bytes", c_bv, 11);
      check("after_abort_end", c_end, 1);

      // One-cycle reset in the middle of the payload.
      clear_tally();
      send_pkt(6'd5, 8'h02, 8'd20, -1, 46);
      step(1'b0, 1'b1, 1'b1, 1'b1);
      check("rst_busy", int'(busy), 0);
      check("rst_byte_out", int'(byte_out), 0);
      idle(2);
      check("rst_no_end", c_end, 0);
      clear_tally();
      send_pkt(6'd5, 8'h02, 8'd20, -1, -1);
      idle(3);
      check("after_rst_bytes", c_bv, 25);
      check("after_rst_end", c_end, 1);

      // Half an access address before reset, the other half after: no match.
      clear_tally();
      for (int i = 0; i < 16; i++) send_bit(AA_V[i]);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 16; i < 32; i++) send_bit(AA_V[i]);
      idle(2);
      check("split_aa_rst", c_sync, 0);
      clear_tally();
      for (int i = 0; i < 16; i++) send_bit(AA_V[i]);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 16; i < 32; i++) send_bit(AA_V[i]);
      idle(2);
      check("split_aa_en", c_sync, 0);

      // Random packets, noise and enable drops.
      for (int r = 0; r < 20; r++) begin
         int rlen, nb;
         rlen = $urandom_range(0, 45);
         nb   = -1;
         repeat ($urandom_range(0, 40)) send_bit(1'($urandom_range(0, 1)));
         if ($urandom_range(0, 5) == 0) nb = $urandom_range(0, (rlen + 5) * 8 - 1);
         send_pkt(6'($urandom_range(0, 39)), 8'($urandom), 8'(rlen), -1, nb);
         if (nb >= 0) repeat ($urandom_range(1, 3)) step(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
         idle(2);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ble_packet_sync.md
BLE_PACKET_SYNC -- requirements
Module: ble_packet_sync

Interface
REQ-001 Parameter AA, default 32'h8E89BED6, access address to correlate against; transmitted LSB-first.
REQ-002 Parameter MAX_ERR, default 0, maximum tolerated bit mismatches between shift register and AA (range 0..4).
REQ-003 Parameter MAX_LEN, default 37, largest accepted PDU length field, in bytes.
REQ-004 clk  input  1  single system clock; all state updates on rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 enable  input  1  1 = process bits; 0 = ignore bits and hold or return to SEARCH.
REQ-007 bit_valid  input  1  one-cycle strobe marking a new demodulated bit (the demodulator's update output).
REQ-008 bit_in  input  1  demodulated bit (the demodulator's value output); sampled only when bit_valid=1.
REQ-009 channel  input  6  BLE channel index 0..39, whitening seed; sampled on the sync_found cycle.
REQ-010 sync_found  output  1  one-cycle pulse on access-address match.
REQ-011 byte_out  output  8  dewhitened byte, LSB = first received bit.
REQ-012 byte_valid  output  1  one-cycle strobe qualifying byte_out.
REQ-013 pkt_end  output  1  one-cycle pulse marking packet termination.
REQ-014 pkt_err  output  1  qualifies pkt_end; 1 = length-field abort.
REQ-015 busy  output  1  high in HEADER and PAYLOAD states.

Function
REQ-016 States: SEARCH, HEADER, PAYLOAD; reset and any abort enter SEARCH.
REQ-017 SEARCH: on bit_valid, 32-bit shift register loads bit_in into bit 31 and shifts right.
REQ-018 Match occurs when the popcount of (shift register XOR AA) is <= MAX_ERR, evaluated on the register value that includes the current bit.
REQ-019 The match check is inhibited until 32 bits have been shifted since entry to SEARCH; the shift register and its bit counter clear on every SEARCH entry.
REQ-020 sync_found is asserted in the cycle after the bit_valid that completes the match; the same edge moves the FSM to HEADER.
REQ-021 On the match edge the whitening LFSR w[0..6] loads w[0]=1, w[1..6]=channel[5..0].
REQ-022 Per payload bit: data = bit_in XOR w[6]; LFSR then shifts w[i]<=w[i-1], w[0]<=w[6], w[4]<=w[3] XOR w[6].
REQ-023 Bytes assemble LSB-first as {data, byte[7:1]}; byte_valid and byte_out are asserted in the cycle after the 8th bit's bit_valid.
REQ-024 HEADER emits 2 bytes; the second dewhitened byte is the length L.
REQ-025 If L > MAX_LEN: pkt_end=1 and pkt_err=1, both coincident with the second header byte_valid; the FSM returns to SEARCH.
REQ-026 Otherwise, PAYLOAD emits L+3 further bytes (PDU plus CRC, CRC not checked); pkt_end=1, pkt_err=0 coincide with the last byte_valid; the FSM returns to SEARCH.
REQ-027 L=0 yields exactly 3 PAYLOAD bytes.
REQ-028 Bits arriving in HEADER/PAYLOAD are never fed to the correlator.
REQ-029 enable=0 in any state: next edge forces SEARCH, with no pkt_end and no byte_valid for a partial byte.
REQ-030 bit_valid is ignored while enable=0; simultaneous bit_valid and enable falling edge: bit discarded.
REQ-031 Outputs sync_found, byte_valid, pkt_end, and pkt_err are single-cycle pulses, even if bit_valid is held high on consecutive cycles.
REQ-032 Consecutive bit_valid on back-to-back cycles is supported at full rate.

Reset
REQ-033 rst_n=0 at a rising edge: state=SEARCH, shift register/counters/LFSR=0, byte_out=8'h00, all single-bit outputs 0.
REQ-034 Reset mid-packet aborts without pkt_end; the first post-reset match requires 32 new bits.

Verification
REQ-035 Preamble 0xAA, then AA LSB-first, channel=37 -> sync_found one cycle after the 32nd AA bit; busy=1 from the following cycle.
REQ-036 Whitened header 0x02,0x06, then 6 PDU bytes and 3 CRC bytes on channel 37 -> 11 byte_valid pulses; dewhitened bytes match the model; pkt_end on the 11th with pkt_err=0.
REQ-037 MAX_ERR=0 with AA having one flipped bit -> no sync_found; same stimulus with MAX_ERR=1 -> sync_found.
REQ-038 Dewhitened length 0x30 (48 > 37) -> pkt_end=1, pkt_err=1 on the 2nd byte; SEARCH follows, and a subsequent valid packet is received.
REQ-039 enable dropped after 20 payload bits, then restored and a new packet sent -> no pkt_end for the aborted packet; the new packet is received intact.
REQ-040 rst_n=0 for one cycle mid-payload -> all outputs 0 next cycle; busy=0; the following packet decodes correctly.
